// File: rtl/canon_pkg.sv
// Shared definitions for the canon player: note frequency table, duration
// decode, scan FSM state type and voice start offset.
package canon_pkg;

   localparam int unsigned FREQ_W       = 10;
   localparam int unsigned VOICE_OFFSET = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA
   } scan_state_e;

   // Codes 18..31 are rests.
   function automatic logic [FREQ_W-1:0] freq_div(input logic [4:0] note);
      logic [FREQ_W-1:0] d;
      case (note)
         5'd0:    d = 10'd0;
         5'd1:    d = 10'd793;
         5'd2:    d = 10'd707;
         5'd3:    d = 10'd667;
         5'd4:    d = 10'd594;
         5'd5:    d = 10'd529;
         5'd6:    d = 10'd499;
         5'd7:    d = 10'd445;
         5'd8:    d = 10'd396;
         5'd9:    d = 10'd353;
         5'd10:   d = 10'd333;
         5'd11:   d = 10'd296;
         5'd12:   d = 10'd264;
         5'd13:   d = 10'd249;
         5'd14:   d = 10'd222;
         5'd15:   d = 10'd197;
         5'd16:   d = 10'd176;
         5'd17:   d = 10'd166;
         default: d = '0;
      endcase
      return d;
   endfunction

   function automatic logic [2:0] dur_mask(input logic [1:0] code);
      return (code == 2'b10) ? 3'b111 : {1'b0, code};
   endfunction

endpackage

// File: rtl/canon_voice_scheduler_if.sv
// Shared note-ROM port: address out from the scheduler, word back one clock later.
interface canon_voice_scheduler_if #(
   parameter int unsigned IDX_W = 9
);
   logic [IDX_W-1:0] rom_addr;
   logic [6:0]       rom_data;

   modport master (output rom_addr, input rom_data);
   modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/canon_voice_scheduler.sv
// Tempo counter, per-voice note indices and a fixed ADDR/DATA scan that
// refreshes each voice's divider and duration mask from the shared note ROM.
module canon_voice_scheduler
   import canon_pkg::*;
#(
   parameter int unsigned NVOICES = 3,
   parameter int unsigned IDX_W   = 9,
   parameter int unsigned TICK_W  = 23,
   parameter int unsigned END_IDX = 288,
   parameter int unsigned DIV_W   = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   canon_voice_scheduler_if.master    rom,
   output logic [NVOICES*DIV_W-1:0]   divider,
   output logic [NVOICES-1:0]         voice_active,
   output logic                       beat,
   output logic                       busy
);

   localparam int unsigned     VW     = (NVOICES > 1) ? $clog2(NVOICES) : 1;
   localparam logic [IDX_W-1:0] END_I  = IDX_W'(END_IDX);
   localparam logic [IDX_W-1:0] LAST_I = IDX_W'(END_IDX - 1);
   localparam logic [VW-1:0]    LAST_V = VW'(NVOICES - 1);

   scan_state_e       state_q, state_d;
   logic [VW-1:0]     voice_q, voice_d;
   logic              start_q, start_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic              beat_q, beat_d;
   logic [2:0]        phase_q, phase_d;
   logic [IDX_W-1:0]  addr_q, addr_d;
   logic [IDX_W-1:0]  idx_q  [NVOICES];
   logic [IDX_W-1:0]  idx_d  [NVOICES];
   logic [DIV_W-1:0]  div_q  [NVOICES];
   logic [DIV_W-1:0]  div_d  [NVOICES];
   logic [2:0]        mask_q [NVOICES];
   logic [2:0]        mask_d [NVOICES];

   always_comb begin
      state_d = state_q;
      voice_d = voice_q;
      start_d = 1'b0;
      phase_d = phase_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      div_d   = div_q;
      mask_d  = mask_q;
      tick_d  = tick_q + TICK_W'(enable);
      beat_d  = enable && (tick_q == '1);

      // Advance decisions use the phase value before this beat's increment.
      if (beat_q) begin
         phase_d = phase_q + 3'd1;
         for (int unsigned v = 0; v < NVOICES; v++) begin
            if ((phase_q & mask_q[v]) == 3'b000) begin
               idx_d[v] = (idx_q[v] == LAST_I) ? '0 : idx_q[v] + IDX_W'(1);
            end
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (start_q || beat_q) begin
               state_d = ST_ADDR;
               voice_d = '0;
               addr_d  = idx_d[0];
            end
         end
         ST_ADDR: state_d = ST_DATA;
         ST_DATA: begin
            if (idx_q[voice_q] >= END_I) begin
               div_d[voice_q]  = '0;
               mask_d[voice_q] = 3'b000;
            end else begin
               div_d[voice_q]  = DIV_W'(freq_div(rom.rom_data[4:0]));
               mask_d[voice_q] = dur_mask(rom.rom_data[6:5]);
            end
            if (voice_q == LAST_V) begin
               state_d = ST_IDLE;
            end else begin
               voice_d = voice_q + VW'(1);
               state_d = ST_ADDR;
               addr_d  = idx_q[voice_d];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         voice_q <= '0;
         start_q <= 1'b1;
         tick_q  <= '0;
         beat_q  <= 1'b0;
         phase_q <= '0;
         addr_q  <= '0;
         for (int unsigned v = 0; v < NVOICES; v++) begin
            idx_q[v]  <= IDX_W'((1 << IDX_W) - VOICE_OFFSET * (v + 1));
            div_q[v]  <= '0;
            mask_q[v] <= 3'b000;
         end
      end else begin
         state_q <= state_d;
         voice_q <= voice_d;
         start_q <= start_d;
         tick_q  <= tick_d;
         beat_q  <= beat_d;
         phase_q <= phase_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      divider      = '0;
      voice_active = '0;
      for (int unsigned v = 0; v < NVOICES; v++) begin
         divider[v*DIV_W +: DIV_W] = div_q[v];
         voice_active[v]           = (idx_q[v] < END_I) && (div_q[v] != '0);
      end
   end

   assign rom.rom_addr = addr_q;
   assign beat         = beat_q;
   assign busy         = (state_q != ST_IDLE);

endmodule
